// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT datapath widths, multiplier constants and the DLOG-to-D helper
package fft_pkg;
    localparam int FFT_WIDTH  = 16;
    localparam int CPLX_WIDTH = 2 * FFT_WIDTH;
    localparam int TW_WIDTH   = 16;
    localparam int TW_FRAC    = TW_WIDTH - 1;
    function automatic int dlog_to_d(input int dlog);
        return 1 << dlog;
    endfunction
endpackage

// File: rtl/sdf_delay_buf.sv
// sdf_delay_buf: D-deep complex feedback RAM, combinational read of the addressed entry
// and synchronous write to the same entry, so each access reads the old value first.
// Ports: clk, we (write enable), addr (entry index), wdata {re,im}, rdata {re,im}.
import fft_pkg::*;
module sdf_delay_buf #(
    parameter int W    = CPLX_WIDTH,
    parameter int ALOG = 2
) (
    input  logic            clk,
    input  logic            we,
    input  logic [ALOG-1:0] addr,
    input  logic [W-1:0]    wdata,
    output logic [W-1:0]    rdata
);
    localparam int D = dlog_to_d(ALOG);
    logic [W-1:0] r_mem [D];
    always_ff @(posedge clk) begin
        if (we) r_mem[addr] <= wdata;
    end
    assign rdata = r_mem[addr];
endmodule

// File: rtl/fft_sdf_stage.sv
// fft_sdf_stage: one radix-2 DIF single-path delay-feedback stage with halving butterflies.
// Ports: clk, rst_n (sync, active-low), din_en/din_re/din_im (input sample),
// dout_en/dout_re/dout_im (output sample), dout_tw (difference needing twiddle),
// tw_addr (twiddle index k, zero unless a valid difference is presented).
import fft_pkg::*;
module fft_sdf_stage #(
    parameter int WIDTH = FFT_WIDTH,
    parameter int DLOG  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_en,
    input  logic [WIDTH-1:0] din_re,
    input  logic [WIDTH-1:0] din_im,
    output logic             dout_en,
    output logic [WIDTH-1:0] dout_re,
    output logic [WIDTH-1:0] dout_im,
    output logic             dout_tw,
    output logic [DLOG-1:0]  tw_addr
);
    logic [DLOG:0]         r_cnt;
    logic                  r_primed;
    logic                  w_phase_b;
    logic [DLOG-1:0]       w_addr;
    logic [2*WIDTH-1:0]    w_rd;
    logic [2*WIDTH-1:0]    w_wr;
    logic [WIDTH-1:0]      w_x_re, w_x_im;
    logic [WIDTH-1:0]      w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic                  w_en_next;

    assign w_phase_b = r_cnt[DLOG];
    assign w_addr    = r_cnt[DLOG-1:0];
    assign w_x_re    = w_rd[2*WIDTH-1:WIDTH];
    assign w_x_im    = w_rd[WIDTH-1:0];

    // One guard bit then an arithmetic halve: the WIDTH-bit result is exact, never wraps.
    assign w_sum_re = WIDTH'(($signed({w_x_re[WIDTH-1], w_x_re}) + $signed({din_re[WIDTH-1], din_re})) >>> 1);
    assign w_sum_im = WIDTH'(($signed({w_x_im[WIDTH-1], w_x_im}) + $signed({din_im[WIDTH-1], din_im})) >>> 1);
    assign w_dif_re = WIDTH'(($signed({w_x_re[WIDTH-1], w_x_re}) - $signed({din_re[WIDTH-1], din_re})) >>> 1);
    assign w_dif_im = WIDTH'(($signed({w_x_im[WIDTH-1], w_x_im}) - $signed({din_im[WIDTH-1], din_im})) >>> 1);

    assign w_wr      = w_phase_b ? {w_dif_re, w_dif_im} : {din_re, din_im};
    // The first phase-B sample primes the stage and is itself a valid output.
    assign w_en_next = din_en & (r_primed | w_phase_b);

    sdf_delay_buf #(.W(2 * WIDTH), .ALOG(DLOG)) u_buf (
        .clk   (clk),
        .we    (din_en),
        .addr  (w_addr),
        .wdata (w_wr),
        .rdata (w_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
            dout_en  <= 1'b0;
            dout_re  <= '0;
            dout_im  <= '0;
            dout_tw  <= 1'b0;
            tw_addr  <= '0;
        end else begin
            dout_en <= w_en_next;
            tw_addr <= (w_en_next && !w_phase_b) ? w_addr : '0;
            if (din_en) begin
                r_cnt    <= r_cnt + 1'b1;
                r_primed <= r_primed | w_phase_b;
                dout_tw  <= !w_phase_b;
                dout_re  <= w_phase_b ? w_sum_re : w_x_re;
                dout_im  <= w_phase_b ? w_sum_im : w_x_im;
            end
        end
    end
endmodule

// File: tb/tb_fft_sdf_stage.sv
// tb_fft_sdf_stage: scoreboard bench for fft_sdf_stage (WIDTH=16, DLOG=2)
module tb_fft_sdf_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_en = 1'b0;
    logic [15:0] din_re = '0;
    logic [15:0] din_im = '0;
    logic        dout_en;
    logic [15:0] dout_re;
    logic [15:0] dout_im;
    logic        dout_tw;
    logic [1:0]  tw_addr;

    fft_sdf_stage #(.WIDTH(16), .DLOG(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_en  (din_en),
        .din_re  (din_re),
        .din_im  (din_im),
        .dout_en (dout_en),
        .dout_re (dout_re),
        .dout_im (dout_im),
        .dout_tw (dout_tw),
        .tw_addr (tw_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        tw;
        logic [1:0]  addr;
    } item_t;

    item_t exp_q[$];
    item_t obs_q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic item_t mk(input logic [15:0] re, input logic [15:0] im, input logic tw, input logic [1:0] addr);
        item_t it;
        it.re = re;
        it.im = im;
        it.tw = tw;
        it.addr = addr;
        return it;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference DIF step: pair k of a frame is (in[k], in[k+D]); sums come out as the
    // second half arrives, halved differences as the next frame's first half arrives.
    int          m_i;
    logic        m_have_prev;
    logic [15:0] m_cur_re [8], m_cur_im [8], m_prev_re [8], m_prev_im [8];

    function automatic logic [15:0] half(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s = sub ? sa - sb : sa + sb;
        return 16'(s >>> 1);
    endfunction

    task automatic model_reset();
        m_i = 0;
        m_have_prev = 1'b0;
    endtask

    task automatic model_push(input logic [15:0] re, input logic [15:0] im);
        if (m_i < 4) begin
            if (m_have_prev)
                exp_q.push_back(mk(half(m_prev_re[m_i], m_prev_re[m_i+4], 1'b1),
                                   half(m_prev_im[m_i], m_prev_im[m_i+4], 1'b1), 1'b1, 2'(m_i)));
        end else begin
            exp_q.push_back(mk(half(m_cur_re[m_i-4], re, 1'b0), half(m_cur_im[m_i-4], im, 1'b0), 1'b0, 2'd0));
        end
        m_cur_re[m_i] = re;
        m_cur_im[m_i] = im;
        m_i++;
        if (m_i == 8) begin
            m_prev_re = m_cur_re;
            m_prev_im = m_cur_im;
            m_have_prev = 1'b1;
            m_i = 0;
        end
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im);
        din_en = 1'b1;
        din_re = re;
        din_im = im;
        model_push(re, im);
        @(posedge clk);
        #1;
        din_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send_rand();
        send(16'($urandom), 16'($urandom));
    endtask

    logic prev_in = 1'b0;
    always @(posedge clk) prev_in <= din_en;

    always @(negedge clk) begin
        if (rst_n && !prev_in) check("idle_en", 64'(dout_en), 64'd0);
        if (dout_en) begin
            obs_q.push_back(mk(dout_re, dout_im, dout_tw, tw_addr));
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got re=%0h im=%0h tw=%0b addr=%0d want no output at %0t",
                         dout_re, dout_im, dout_tw, tw_addr, $time);
            end else begin
                check("out", 64'(mk(dout_re, dout_im, dout_tw, tw_addr)), 64'(exp_q.pop_front()));
            end
        end
    end

    item_t imp_tbl [12];
    item_t ext_tbl [8];

    initial begin
        model_reset();
        for (int k = 0; k < 4; k++) begin
            imp_tbl[k]   = mk(k == 0 ? 16'd500 : 16'd0, 16'd0, 1'b0, 2'd0);
            imp_tbl[k+4] = mk(k == 0 ? 16'd500 : 16'd0, 16'd0, 1'b1, 2'(k));
            imp_tbl[k+8] = mk(16'd0, 16'd0, 1'b0, 2'd0);
        end
        ext_tbl[0] = mk(16'h7fff, 16'd0, 1'b0, 2'd0);
        ext_tbl[1] = mk(16'hffff, 16'd0, 1'b0, 2'd0);
        ext_tbl[2] = mk(16'hffff, 16'd0, 1'b0, 2'd0);
        ext_tbl[3] = mk(16'h0000, 16'd0, 1'b0, 2'd0);
        ext_tbl[4] = mk(16'h0000, 16'd0, 1'b1, 2'd0);
        ext_tbl[5] = mk(16'h8000, 16'd0, 1'b1, 2'd1);
        ext_tbl[6] = mk(16'h7fff, 16'd0, 1'b1, 2'd2);
        ext_tbl[7] = mk(16'h0000, 16'd0, 1'b1, 2'd3);

        rst_n = 1'b0;
        din_en = 1'b1;
        din_re = 16'h1234;
        din_im = 16'h5678;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_en", 64'(dout_en), 64'd0);
            check("rst_re", 64'(dout_re), 64'd0);
            check("rst_im", 64'(dout_im), 64'd0);
            check("rst_tw", 64'(dout_tw), 64'd0);
            check("rst_addr", 64'(tw_addr), 64'd0);
        end
        din_en = 1'b0;
        rst_n = 1'b1;
        model_reset();

        obs_q.delete();
        send(16'd1000, 16'd0);
        repeat (15) send(16'd0, 16'd0);
        idle(2);
        check("imp_count", 64'(obs_q.size()), 64'd12);
        for (int k = 0; k < 12 && k < obs_q.size(); k++) check("imp_val", 64'(obs_q[k]), 64'(imp_tbl[k]));

        do_reset();
        obs_q.delete();
        send(16'h7fff, 16'd0);
        send(16'h8000, 16'd0);
        send(16'h7fff, 16'd0);
        send(16'h0000, 16'd0);
        send(16'h7fff, 16'd0);
        send(16'h7fff, 16'd0);
        send(16'h8000, 16'd0);
        send(16'h0000, 16'd0);
        repeat (4) send(16'd0, 16'd0);
        idle(2);
        check("ext_count", 64'(obs_q.size()), 64'd8);
        for (int k = 0; k < 8 && k < obs_q.size(); k++) check("ext_val", 64'(obs_q[k]), 64'(ext_tbl[k]));

        do_reset();
        for (int f = 0; f < 32; f++) begin
            send_rand();
            idle($urandom_range(1, 3));
        end
        idle(2);
        check("gap_drain", 64'(exp_q.size()), 64'd0);

        do_reset();
        repeat (6) send_rand();
        idle(2);
        check("mid_drain", 64'(exp_q.size()), 64'd0);
        do_reset();
        repeat (24) send_rand();
        idle(2);

        do_reset();
        repeat (8000) send_rand();
        idle(3);
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
